// File: rtl/dmem_lat_if.sv
`default_nettype none
// ============================================================
// Module : dmem_lat_if
// Request/response and backdoor bundle for dmem_lat.
// Rev    : 1.0
// ============================================================
interface dmem_lat_if #(
  parameter int LINE_W = 256,
  parameter int DEPTH  = 512,
  parameter int ADDR_W = 32
);
  localparam int IDX_W = $clog2(DEPTH);

  logic [ADDR_W-1:0] addr_i;
  logic [LINE_W-1:0] data_i;
  logic              enable_i;
  logic              write_i;
  logic              ack_o;
  logic [LINE_W-1:0] data_o;
  logic              err_o;
  logic              busy_o;
  logic              bd_we_i;
  logic [IDX_W-1:0]  bd_idx_i;
  logic [LINE_W-1:0] bd_data_i;
  logic [31:0]       rd_cnt_o;
  logic [31:0]       wr_cnt_o;

  modport master (
    output addr_i, data_i, enable_i, write_i, bd_we_i, bd_idx_i, bd_data_i,
    input  ack_o, data_o, err_o, busy_o, rd_cnt_o, wr_cnt_o
  );

  modport slave (
    input  addr_i, data_i, enable_i, write_i, bd_we_i, bd_idx_i, bd_data_i,
    output ack_o, data_o, err_o, busy_o, rd_cnt_o, wr_cnt_o
  );
endinterface
`default_nettype wire

// File: rtl/dmem_lat.sv
`default_nettype none
// ============================================================
// Module : dmem_lat
// Line-oriented data memory with configurable access latency.
// Rev    : 1.0
// ============================================================
module dmem_lat #(
  parameter int LINE_W  = 256,
  parameter int DEPTH   = 512,
  parameter int ADDR_W  = 32,
  parameter int LATENCY = 10
) (
  input  logic        clk_i,
  input  logic        rst_i,
  dmem_lat_if.slave   bus
);
  localparam int OFS   = $clog2(LINE_W / 8);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] C_CNT_LOAD = CNT_W'(LATENCY - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_ACK  = 2'd2;

  logic [1:0]        r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;

  logic [IDX_W-1:0]  r_idx;
  logic [LINE_W-1:0] r_wdata;
  logic              r_write;
  logic              r_oor;

  logic [LINE_W-1:0] r_mem [DEPTH];

  logic              r_ack, r_err, r_busy;
  logic [LINE_W-1:0] r_rdata;
  logic [31:0]       r_rd_cnt, r_wr_cnt;

  logic              w_accept, w_oor_in;
  logic [IDX_W-1:0]  w_idx_in;
  logic [IDX_W-1:0]  w_cur_idx;
  logic [LINE_W-1:0] w_cur_wdata;
  logic              w_cur_write, w_cur_oor;
  logic              w_enter_ack, w_do_wr, w_do_rd, w_busy_nxt, w_ack_nxt, w_err_nxt;

  assign w_idx_in = bus.addr_i[OFS +: IDX_W];
  assign w_oor_in = ((bus.addr_i >> (OFS + IDX_W)) != '0) || (bus.addr_i[OFS-1:0] != '0);
  assign w_accept = (r_state == S_IDLE) && bus.enable_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (bus.enable_i) begin
          w_cnt_nxt   = C_CNT_LOAD;
          w_state_nxt = (LATENCY == 1) ? S_ACK : S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_cnt == CNT_W'(1)) begin
          w_state_nxt = S_ACK;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      S_ACK:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // With LATENCY = 1 the ACK transition happens on the accepting edge, so the
  // live request must be used instead of the not-yet-latched copy.
  always_comb begin
    w_cur_idx   = (r_state == S_IDLE) ? w_idx_in    : r_idx;
    w_cur_wdata = (r_state == S_IDLE) ? bus.data_i  : r_wdata;
    w_cur_write = (r_state == S_IDLE) ? bus.write_i : r_write;
    w_cur_oor   = (r_state == S_IDLE) ? w_oor_in    : r_oor;
    w_enter_ack = (w_state_nxt == S_ACK) && !rst_i;
    w_do_wr     = w_enter_ack && w_cur_write && !w_cur_oor;
    w_do_rd     = w_enter_ack && !w_cur_write && !w_cur_oor;
    w_busy_nxt  = (w_state_nxt != S_IDLE) || (r_state == S_ACK);
    w_ack_nxt   = (r_state == S_ACK);
    w_err_nxt   = (r_state == S_ACK) && r_oor;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_idx    <= '0;
      r_wdata  <= '0;
      r_write  <= 1'b0;
      r_oor    <= 1'b0;
      r_ack    <= 1'b0;
      r_err    <= 1'b0;
      r_busy   <= 1'b0;
      r_rdata  <= '0;
      r_rd_cnt <= '0;
      r_wr_cnt <= '0;
    end else begin
      if (w_accept) begin
        r_idx   <= w_idx_in;
        r_wdata <= bus.data_i;
        r_write <= bus.write_i;
        r_oor   <= w_oor_in;
      end
      r_ack  <= w_ack_nxt;
      r_err  <= w_err_nxt;
      r_busy <= w_busy_nxt;
      if (w_enter_ack && w_cur_oor) begin
        r_rdata <= '0;
      end else if (w_do_rd) begin
        r_rdata <= r_mem[w_cur_idx];
      end
      if (w_do_rd) begin
        r_rd_cnt <= r_rd_cnt + 32'd1;
      end
      if (w_do_wr) begin
        r_wr_cnt <= r_wr_cnt + 32'd1;
      end
    end
  end

  // Backdoor is applied last so it wins a same-index collision.
  always_ff @(posedge clk_i) begin
    if (w_do_wr) begin
      r_mem[w_cur_idx] <= w_cur_wdata;
    end
    if (bus.bd_we_i) begin
      r_mem[bus.bd_idx_i] <= bus.bd_data_i;
    end
  end

  assign bus.ack_o    = r_ack;
  assign bus.err_o    = r_err;
  assign bus.busy_o   = r_busy;
  assign bus.data_o   = r_rdata;
  assign bus.rd_cnt_o = r_rd_cnt;
  assign bus.wr_cnt_o = r_wr_cnt;
endmodule
`default_nettype wire
